stack_access_unit: RTL and testbench

- Stack engine that consumes the stack-pointer interface. It executes PUSH, POP, CALL and RET stack traffic against the 16-bit-word data memory.
- It owns a synchronous SP register and splits each 32-bit operand into two 16-bit memory beats. It updates SP by ±1 for 16-bit operands and ±2 for 32-bit operands.
- It sits between decode/execute (request side) and the data-memory port (memory side).

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_access_unit.sv | 171 +++++++++++++++++
 tb/tb_stack_access_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module : stack_pkg
// Brief  : Shared state encoding, operation/size codes and SP bounds for the
//          stack access unit.
// Rev    : 1.0  initial release
// ============================================================================
package stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;
  localparam logic SZ_16   = 1'b0;
  localparam logic SZ_32   = 1'b1;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'd1048575;
  localparam logic [31:0] SP_LIMIT_DEFAULT = 32'd1047552;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_access_unit.sv
`default_nettype none
// ============================================================================
// Module : stack_access_unit
// Brief  : Empty-descending stack engine; turns PUSH/POP requests into one or
//          two 16-bit data-memory beats and maintains the SP register.
// Rev    : 1.0  initial release
// ============================================================================
module stack_access_unit
  import stack_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT,
  parameter logic [31:0] SP_LIMIT = SP_LIMIT_DEFAULT,
  parameter int          ADDR_W   = 20
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Pop,
  input  logic              Req_Wide,
  input  logic [31:0]       Req_Data,
  output logic              Resp_Valid,
  output logic [31:0]       Resp_Data,
  output logic              Resp_Err,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_WData,
  input  logic [15:0]       Mem_RData,
  input  logic              Mem_Ack,
  output logic [31:0]       SP_Out
);

  state_t              r_state;
  logic [31:0]         r_sp;
  logic                r_pop;
  logic                r_wide;
  logic [31:0]         r_data;
  logic [15:0]         r_lo;
  logic                r_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_data;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;

  logic [31:0] w_size;
  logic [31:0] w_sp_dec;
  logic [31:0] w_sp_inc;
  logic [31:0] w_sp_m1;
  logic [31:0] w_sp_p1;
  logic [31:0] w_sp_p2;
  logic [31:0] w_sp_next;
  logic        w_err;

  // Bounds are evaluated on the latched request while in CHECK; SP never wraps.
  assign w_size    = (r_wide == SZ_32) ? 32'd2 : 32'd1;
  assign w_sp_dec  = r_sp - w_size;
  assign w_sp_inc  = r_sp + w_size;
  assign w_sp_m1   = r_sp - 32'd1;
  assign w_sp_p1   = r_sp + 32'd1;
  assign w_sp_p2   = r_sp + 32'd2;
  assign w_sp_next = (r_pop == OP_POP) ? w_sp_inc : w_sp_dec;
  assign w_err     = (r_pop == OP_POP) ? (w_sp_inc > SP_RESET)
                                       : (w_sp_dec < (SP_LIMIT - 32'd1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_sp         <= SP_RESET;
      r_pop        <= OP_PUSH;
      r_wide       <= SZ_16;
      r_data       <= 32'd0;
      r_lo         <= 16'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Req_Valid && r_ready) begin
            r_pop   <= Req_Pop;
            r_wide  <= Req_Wide;
            r_data  <= Req_Data;
            r_ready <= 1'b0;
            r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (w_err) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= 32'd0;
            r_state      <= ST_RESP;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (r_pop == OP_PUSH);
            r_mem_addr  <= (r_pop == OP_POP) ? w_sp_p1[ADDR_W-1:0] : r_sp[ADDR_W-1:0];
            r_mem_wdata <= (r_wide == SZ_32) ? r_data[31:16] : r_data[15:0];
            r_state     <= ST_BEAT0;
          end
        end

        ST_BEAT0: begin
          if (Mem_Ack) begin
            r_lo <= Mem_RData;
            if (r_wide == SZ_32) begin
              r_mem_addr  <= (r_pop == OP_POP) ? w_sp_p2[ADDR_W-1:0] : w_sp_m1[ADDR_W-1:0];
              r_mem_wdata <= r_data[15:0];
              r_state     <= ST_BEAT1;
            end else begin
              r_mem_req    <= 1'b0;
              r_mem_we     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_data  <= (r_pop == OP_POP) ? {16'd0, Mem_RData} : 32'd0;
              r_sp         <= w_sp_next;
              r_state      <= ST_RESP;
            end
          end
        end

        ST_BEAT1: begin
          if (Mem_Ack) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= (r_pop == OP_POP) ? {Mem_RData, r_lo} : 32'd0;
            r_sp         <= w_sp_next;
            r_state      <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign Req_Ready  = r_ready;
  assign Resp_Valid = r_resp_valid;
  assign Resp_Data  = r_resp_data;
  assign Resp_Err   = r_resp_err;
  assign Mem_Req    = r_mem_req;
  assign Mem_We     = r_mem_we;
  assign Mem_Addr   = r_mem_addr;
  assign Mem_WData  = r_mem_wdata;
  assign SP_Out     = r_sp;

endmodule : stack_access_unit
`default_nettype wire

// File: tb/tb_stack_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_stack_access_unit
// Brief  : Directed self-checking bench with a small 16-bit memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_stack_access_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Pop = 1'b0;
  logic        Req_Wide = 1'b0;
  logic [31:0] Req_Data = 32'd0;
  logic        Resp_Valid;
  logic [31:0] Resp_Data;
  logic        Resp_Err;
  logic        Mem_Req;
  logic        Mem_We;
  logic [19:0] Mem_Addr;
  logic [15:0] Mem_WData;
  logic [15:0] Mem_RData;
  logic        Mem_Ack;
  logic [31:0] SP_Out;

  int checks = 0;
  int failures = 0;

  stack_access_unit dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Pop(Req_Pop),
    .Req_Wide(Req_Wide), .Req_Data(Req_Data),
    .Resp_Valid(Resp_Valid), .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack),
    .SP_Out(SP_Out)
  );

  always #5 Clk = ~Clk;

  // Memory model covering the top 1024 words; ack after ack_delay wait cycles.
  logic [15:0] mem [0:1023];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          beat_n    = 0;
  logic [19:0] beat_addr [0:7];
  logic [15:0] beat_data [0:7];
  logic        beat_we   [0:7];

  assign Mem_Ack   = Mem_Req && (wait_cnt >= ack_delay);
  assign Mem_RData = mem[Mem_Addr[9:0]];

  always @(posedge Clk) begin
    if (Mem_Req && Mem_Ack) begin
      if (Mem_We) mem[Mem_Addr[9:0]] <= Mem_WData;
      beat_addr[beat_n % 8] <= Mem_Addr;
      beat_data[beat_n % 8] <= Mem_We ? Mem_WData : Mem_RData;
      beat_we[beat_n % 8]   <= Mem_We;
      beat_n   <= beat_n + 1;
      wait_cnt <= 0;
    end else if (Mem_Req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Beat signals must not move while a beat waits for its ack.
  int          unstable = 0;
  logic        prev_req = 1'b0;
  int          prev_beat = 0;
  logic [19:0] prev_addr = '0;
  logic [15:0] prev_wd = '0;
  logic        prev_we = 1'b0;
  always @(negedge Clk) begin
    if (Mem_Req && prev_req && (beat_n == prev_beat) &&
        ((Mem_Addr !== prev_addr) || (Mem_WData !== prev_wd) || (Mem_We !== prev_we)))
      unstable = unstable + 1;
    prev_req  = Mem_Req;
    prev_beat = beat_n;
    prev_addr = Mem_Addr;
    prev_wd   = Mem_WData;
    prev_we   = Mem_We;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request; returns cycles from acceptance to Resp_Valid (-1 on timeout).
  task automatic do_op(input logic pop, input logic wide, input logic [31:0] data,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int beats);
    int base;
    int guard;
    @(negedge Clk);
    guard = 0;
    while (!Req_Ready && guard < 20) begin @(negedge Clk); guard++; end
    Req_Valid = 1'b1; Req_Pop = pop; Req_Wide = wide; Req_Data = data;
    base = beat_n;
    @(negedge Clk);
    Req_Valid = 1'b0;
    lat = 1;
    while (!Resp_Valid && lat < 60) begin @(negedge Clk); lat++; end
    if (!Resp_Valid) lat = -1;
    rdata = Resp_Data;
    err   = Resp_Err;
    beats = beat_n - base;
  endtask

  int          lat;
  int          beats;
  logic [31:0] rd;
  logic        er;
  int          base0;
  int          guard0;

  initial begin
    // Reset
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_ready",     {31'd0, Req_Ready},  32'd1);
    chk("rst_resp_vld",  {31'd0, Resp_Valid}, 32'd0);
    chk("rst_mem_req",   {31'd0, Mem_Req},    32'd0);
    chk("rst_mem_addr",  {12'd0, Mem_Addr},   32'd0);
    chk("rst_resp_data", Resp_Data,           32'd0);
    chk("rst_sp",        SP_Out,              32'd1048575);

    // Pop16 on empty stack underflows
    do_op(1'b1, 1'b0, 32'd0, lat, rd, er, beats);
    chk("unf_lat",   lat, 32'd2);
    chk("unf_err",   {31'd0, er}, 32'd1);
    chk("unf_beats", beats, 32'd0);
    chk("unf_sp",    SP_Out, 32'd1048575);

    // Push32 0xDEADBEEF, zero-wait memory
    do_op(1'b0, 1'b1, 32'hDEADBEEF, lat, rd, er, beats);
    chk("p32_lat",   lat, 32'd4);
    chk("p32_err",   {31'd0, er}, 32'd0);
    chk("p32_rdata", rd, 32'd0);
    chk("p32_beats", beats, 32'd2);
    chk("p32_a0",    {12'd0, beat_addr[(beat_n-2)%8]}, 32'h000FFFFF);
    chk("p32_d0",    {16'd0, beat_data[(beat_n-2)%8]}, 32'h0000DEAD);
    chk("p32_we0",   {31'd0, beat_we[(beat_n-2)%8]},   32'd1);
    chk("p32_a1",    {12'd0, beat_addr[(beat_n-1)%8]}, 32'h000FFFFE);
    chk("p32_d1",    {16'd0, beat_data[(beat_n-1)%8]}, 32'h0000BEEF);
    @(negedge Clk);
    chk("p32_sp",    SP_Out, 32'd1048573);

    // Pop32 reads it back
    do_op(1'b1, 1'b1, 32'd0, lat, rd, er, beats);
    chk("o32_lat",   lat, 32'd4);
    chk("o32_data",  rd, 32'hDEADBEEF);
    chk("o32_a0",    {12'd0, beat_addr[(beat_n-2)%8]}, 32'h000FFFFE);
    chk("o32_we0",   {31'd0, beat_we[(beat_n-2)%8]},   32'd0);
    chk("o32_a1",    {12'd0, beat_addr[(beat_n-1)%8]}, 32'h000FFFFF);
    @(negedge Clk);
    chk("o32_sp",    SP_Out, 32'd1048575);

    // Narrow push/pop round trip, upper bits zero-extended
    do_op(1'b0, 1'b0, 32'hAAAA1234, lat, rd, er, beats);
    chk("p16_lat",   lat, 32'd3);
    chk("p16_d0",    {16'd0, beat_data[(beat_n-1)%8]}, 32'h00001234);
    @(negedge Clk);
    chk("p16_sp",    SP_Out, 32'd1048574);
    do_op(1'b1, 1'b0, 32'd0, lat, rd, er, beats);
    chk("o16_data",  rd, 32'h00001234);
    chk("o16_a0",    {12'd0, beat_addr[(beat_n-1)%8]}, 32'h000FFFFF);
    @(negedge Clk);
    chk("o16_sp",    SP_Out, 32'd1048575);

    // Push32 with three wait cycles per beat
    ack_delay = 3;
    unstable  = 0;
    do_op(1'b0, 1'b1, 32'hCAFEF00D, lat, rd, er, beats);
    chk("stl_lat",    lat, 32'd10);
    chk("stl_beats",  beats, 32'd2);
    chk("stl_stable", unstable, 32'd0);
    chk("stl_d0",     {16'd0, beat_data[(beat_n-2)%8]}, 32'h0000CAFE);
    chk("stl_d1",     {16'd0, beat_data[(beat_n-1)%8]}, 32'h0000F00D);
    do_op(1'b1, 1'b1, 32'd0, lat, rd, er, beats);
    chk("stl_pop",    rd, 32'hCAFEF00D);
    ack_delay = 0;

    // Fill down to SP_LIMIT with narrow pushes, then overflow with a wide push
    for (int i = 0; i < 1023; i++) begin
      do_op(1'b0, 1'b0, i, lat, rd, er, beats);
      if (er || lat < 0) chk("fill_ok", {31'd0, er}, 32'd0);
    end
    @(negedge Clk);
    chk("fill_sp",   SP_Out, 32'd1047552);
    do_op(1'b0, 1'b1, 32'h11112222, lat, rd, er, beats);
    chk("ovf_err",   {31'd0, er}, 32'd1);
    chk("ovf_beats", beats, 32'd0);
    @(negedge Clk);
    chk("ovf_sp",    SP_Out, 32'd1047552);

    // Reset while the second beat of a Push32 is stalled
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    ack_delay = 2;
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Pop = 1'b0; Req_Wide = 1'b1; Req_Data = 32'h01020304;
    base0 = beat_n;
    @(negedge Clk);
    Req_Valid = 1'b0;
    guard0 = 0;
    while (!((beat_n == base0 + 1) && Mem_Req) && guard0 < 20) begin
      @(negedge Clk); guard0++;
    end
    chk("mid_in_beat1", {31'd0, (beat_n == base0 + 1) && Mem_Req}, 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("mid_mem_req",  {31'd0, Mem_Req},    32'd0);
    chk("mid_sp",       SP_Out,              32'd1048575);
    chk("mid_resp_vld", {31'd0, Resp_Valid}, 32'd0);
    chk("mid_beats",    beat_n - base0,      32'd1);
    @(negedge Clk);
    chk("mid_ready",    {31'd0, Req_Ready},  32'd1);
    chk("mid_resp_vl2", {31'd0, Resp_Valid}, 32'd0);
    chk("mid_mem_req2", {31'd0, Mem_Req},    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_stack_access_unit
`default_nettype wire
